// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address/instruction widths, reset vector
// default and the fetch sequencer state encoding.
package cpu_pkg;

   localparam int ADDR_W  = 15;
   localparam int INSTR_W = 16;

   localparam logic [ADDR_W-1:0] RESET_VEC_DEF = 15'h0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      REDIR = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads memory at the PC over req/ack, holds the
// word in ir for decode, and steers the PC through increments and redirects.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic               pc_load,
   output logic               pc_inc,
   output logic [ADDR_W-1:0]  pc_target,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               br_req,
   input  logic [ADDR_W-1:0]  br_target
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               pc_load_q, pc_load_d;
   logic               pc_inc_q, pc_inc_d;
   logic [ADDR_W-1:0]  pc_target_q, pc_target_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               ir_valid_q, ir_valid_d;

   // Request is masked by rst so an in-flight read is abandoned at once.
   assign mem_req   = !rst && ((state_q == FETCH) || (state_q == DRAIN));
   assign mem_addr  = (state_q == DRAIN) ? addr_q : pc_addr;
   assign pc_load   = pc_load_q;
   assign pc_inc    = pc_inc_q;
   assign pc_target = pc_target_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pc_load_d   = 1'b0;
      pc_inc_d    = 1'b0;
      pc_target_d = pc_target_q;
      ir_d        = ir_q;
      ir_valid_d  = ir_valid_q;
      case (state_q)
         FETCH: begin
            addr_d = pc_addr;
            if (br_req) begin
               pc_load_d   = 1'b1;
               pc_target_d = br_target;
               state_d     = mem_ack ? REDIR : DRAIN;
            end else if (mem_ack) begin
               ir_d       = mem_rdata;
               ir_valid_d = 1'b1;
               pc_inc_d   = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (br_req) begin
               ir_valid_d  = 1'b0;
               pc_load_d   = 1'b1;
               pc_target_d = br_target;
               state_d     = REDIR;
            end else if (ir_ready) begin
               ir_valid_d = 1'b0;
               state_d    = FETCH;
            end
         end
         REDIR: begin
            if (br_req) begin
               pc_load_d   = 1'b1;
               pc_target_d = br_target;
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            // The outstanding read must complete before req may drop; its data is stale.
            if (br_req) begin
               pc_load_d   = 1'b1;
               pc_target_d = br_target;
            end
            if (mem_ack) begin
               state_d = br_req ? REDIR : FETCH;
            end
         end
         default: state_d = REDIR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= REDIR;
         addr_q      <= '0;
         pc_load_q   <= 1'b1;
         pc_inc_q    <= 1'b0;
         pc_target_q <= RESET_VEC;
         ir_q        <= '0;
         ir_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pc_load_q   <= pc_load_d;
         pc_inc_q    <= pc_inc_d;
         pc_target_q <= pc_target_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC and memory behavioural models plus a
// program-order model of the instruction stream delivered to decode.
module tb_fetch_unit;

   localparam logic [14:0] RV = 15'h0010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] pc = 15'h7abc;
   logic        pc_load, pc_inc, mem_req, mem_ack = 1'b0, ir_valid;
   logic [14:0] pc_target, mem_addr;
   logic [15:0] mem_rdata = '0, ir;
   logic        ir_ready = 1'b1, br_req = 1'b0;
   logic [14:0] br_target = '0;

   int n_tests = 0, n_fail = 0, n_deliv = 0;
   int mem_wait = 0, wcnt = 0;
   bit rand_wait = 0;
   bit prev_pend = 0;
   logic [14:0] prev_addr = '0, exp_addr = RV;

   logic        s_mem_req, s_mem_ack, s_pc_load, s_pc_inc, s_ir_valid;
   logic [14:0] s_mem_addr, s_pc_target;
   logic [15:0] s_ir;

   fetch_unit #(.RESET_VEC(RV)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc), .pc_load(pc_load), .pc_inc(pc_inc),
      .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .br_req(br_req), .br_target(br_target)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (limit 2000000, reached)");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] mword(input logic [14:0] a);
      return {a[3:0], a[14:3]} ^ 16'hc35a;
   endfunction

   // One clock: memory answers at negedge, outputs sampled there, models advance after posedge.
   task automatic cycle();
      @(negedge clk);
      if (rst || !mem_req) begin
         mem_ack = 1'b0;
      end else begin
         if (wcnt == 0 && rand_wait) mem_wait = $urandom_range(0, 3);
         mem_ack = (wcnt >= mem_wait);
      end
      mem_rdata   = mem_ack ? mword(mem_addr) : 16'($urandom);
      s_mem_req   = mem_req;   s_mem_addr  = mem_addr; s_mem_ack = mem_ack;
      s_pc_load   = pc_load;   s_pc_inc    = pc_inc;   s_pc_target = pc_target;
      s_ir        = ir;        s_ir_valid  = ir_valid;
      if (!rst) begin
         n_tests++;
         if (pc_load === 1'b1 && pc_inc === 1'b1) begin
            n_fail++;
            $display("FAIL load_inc_exclusive: pc_load=%b pc_inc=%b, required not both 1", pc_load, pc_inc);
         end
      end
      if (prev_pend && !rst) begin
         n_tests++;
         if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
            n_fail++;
            $display("FAIL req_held: mem_req=%b mem_addr=%h, required 1 / %h", mem_req, mem_addr, prev_addr);
         end
      end
      if (!rst && !br_req && ir_valid === 1'b1 && ir_ready) begin
         n_tests++;
         n_deliv++;
         if (ir !== mword(exp_addr)) begin
            n_fail++;
            $display("FAIL delivered_word: ir=%h, required %h (addr %h)", ir, mword(exp_addr), exp_addr);
         end
      end
      @(posedge clk);
      #1;
      if (s_pc_inc === 1'b1) pc = pc + 15'd1;
      else if (s_pc_load === 1'b1) pc = s_pc_target;
      if (rst) exp_addr = RV;
      else if (br_req) exp_addr = br_target;
      else if (s_ir_valid === 1'b1 && ir_ready) exp_addr = exp_addr + 15'd1;
      wcnt      = (s_mem_req && !s_mem_ack && !rst) ? wcnt + 1 : 0;
      prev_pend = s_mem_req && !s_mem_ack && !rst;
      prev_addr = s_mem_addr;
   endtask

   task automatic do_reset();
      rst = 1'b1; br_req = 1'b0; rand_wait = 0;
      cycle(); cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      mem_wait = 0; ir_ready = 1'b1;
      do_reset();
      cycle();
      n_tests++;
      if (s_pc_load !== 1'b1 || s_pc_target !== RV || s_pc_inc !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pc_ctl: load=%b target=%h inc=%b, required 1/%h/0", s_pc_load, s_pc_target, s_pc_inc, RV);
      end
      n_tests++;
      if (s_ir !== 16'h0 || s_ir_valid !== 1'b0 || s_mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ir_req: ir=%h valid=%b req=%b, required 0/0/0", s_ir, s_ir_valid, s_mem_req);
      end
      cycle();
      n_tests++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== RV) begin
         n_fail++;
         $display("FAIL first_fetch: req=%b addr=%h, required 1/%h", s_mem_req, s_mem_addr, RV);
      end
      cycle();
      n_tests++;
      if (s_ir_valid !== 1'b1 || s_ir !== mword(RV) || s_pc_inc !== 1'b1 || s_mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL first_hold: valid=%b ir=%h inc=%b req=%b, required 1/%h/1/0", s_ir_valid, s_ir, s_pc_inc, s_mem_req, mword(RV));
      end
      cycle();
      n_tests++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== RV + 15'd1 || s_ir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL second_fetch: req=%b addr=%h valid=%b, required 1/%h/0", s_mem_req, s_mem_addr, s_ir_valid, RV + 15'd1);
      end
      cycle();
      n_tests++;
      if (s_ir_valid !== 1'b1 || s_ir !== mword(RV + 15'd1)) begin
         n_fail++;
         $display("FAIL second_hold: valid=%b ir=%h, required 1/%h", s_ir_valid, s_ir, mword(RV + 15'd1));
      end
   endtask

   task automatic test_mem_wait();
      int req_n = 0;
      bit addr_ok = 1, ir_early = 0;
      do_reset(); cycle();
      mem_wait = 3; ir_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (s_ir_valid === 1'b1) break;
         if (s_mem_req === 1'b1) begin
            req_n++;
            if (s_mem_addr !== RV) addr_ok = 0;
            if (s_ir !== 16'h0) ir_early = 1;
         end
      end
      n_tests++;
      if (req_n != 4 || !addr_ok || ir_early) begin
         n_fail++;
         $display("FAIL wait_req: req_cycles=%0d addr_ok=%0d ir_early=%0d, required 4/1/0", req_n, addr_ok, ir_early);
      end
      n_tests++;
      if (s_ir_valid !== 1'b1 || s_ir !== mword(RV)) begin
         n_fail++;
         $display("FAIL wait_capture: valid=%b ir=%h, required 1/%h", s_ir_valid, s_ir, mword(RV));
      end
   endtask

   task automatic test_hold_stall();
      logic [15:0] ir0 = '0;
      bit stable = 1, any_req = 0;
      int inc_n = 0;
      do_reset(); cycle();
      mem_wait = 0; ir_ready = 1'b0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (i == 0) ir0 = s_ir;
         if (s_ir !== ir0 || s_ir_valid !== 1'b1) stable = 0;
         if (s_mem_req !== 1'b0) any_req = 1;
         if (s_pc_inc === 1'b1) inc_n++;
      end
      n_tests++;
      if (!stable || any_req || inc_n != 1 || ir0 !== mword(RV)) begin
         n_fail++;
         $display("FAIL hold_stall: stable=%0d req=%0d inc_pulses=%0d ir=%h, required 1/0/1/%h", stable, any_req, inc_n, ir0, mword(RV));
      end
      ir_ready = 1'b1;
      cycle(); cycle();
      n_tests++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== RV + 15'd1) begin
         n_fail++;
         $display("FAIL hold_release: req=%b addr=%h, required 1/%h", s_mem_req, s_mem_addr, RV + 15'd1);
      end
   endtask

   task automatic test_branch_drain();
      bit no_valid = 1;
      do_reset(); cycle();
      mem_wait = 2; ir_ready = 1'b1;
      br_req = 1'b1; br_target = 15'h0200;
      cycle();
      if (s_ir_valid !== 1'b0) no_valid = 0;
      br_req = 1'b0;
      cycle();
      if (s_ir_valid !== 1'b0) no_valid = 0;
      n_tests++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== RV || s_pc_load !== 1'b1 || s_pc_target !== 15'h0200) begin
         n_fail++;
         $display("FAIL drain_state: req=%b addr=%h load=%b target=%h, required 1/%h/1/0200", s_mem_req, s_mem_addr, s_pc_load, s_pc_target, RV);
      end
      cycle();
      if (s_ir_valid !== 1'b0) no_valid = 0;
      n_tests++;
      if (s_mem_ack !== 1'b1 || s_mem_addr !== RV) begin
         n_fail++;
         $display("FAIL drain_ack: ack=%b addr=%h, required 1/%h", s_mem_ack, s_mem_addr, RV);
      end
      cycle();
      if (s_ir_valid !== 1'b0) no_valid = 0;
      n_tests++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== 15'h0200 || !no_valid) begin
         n_fail++;
         $display("FAIL drain_refetch: req=%b addr=%h no_valid=%0d, required 1/0200/1", s_mem_req, s_mem_addr, no_valid);
      end
   endtask

   task automatic test_br_hold();
      do_reset(); cycle();
      mem_wait = 0; ir_ready = 1'b1;
      cycle();
      br_req = 1'b1; br_target = 15'h0300;
      cycle();
      n_tests++;
      if (s_ir_valid !== 1'b1 || s_pc_inc !== 1'b1 || s_pc_load !== 1'b0) begin
         n_fail++;
         $display("FAIL br_hold_entry: valid=%b inc=%b load=%b, required 1/1/0", s_ir_valid, s_pc_inc, s_pc_load);
      end
      br_req = 1'b0;
      cycle();
      n_tests++;
      if (s_ir_valid !== 1'b0 || s_pc_load !== 1'b1 || s_pc_target !== 15'h0300 || s_pc_inc !== 1'b0) begin
         n_fail++;
         $display("FAIL br_hold_redir: valid=%b load=%b target=%h inc=%b, required 0/1/0300/0", s_ir_valid, s_pc_load, s_pc_target, s_pc_inc);
      end
      cycle();
      n_tests++;
      if (s_mem_req !== 1'b1 || s_mem_addr !== 15'h0300) begin
         n_fail++;
         $display("FAIL br_hold_fetch: req=%b addr=%h, required 1/0300", s_mem_req, s_mem_addr);
      end
   endtask

   task automatic test_rst_drain();
      bit early = 0;
      do_reset(); cycle();
      mem_wait = 10; ir_ready = 1'b1;
      br_req = 1'b1; br_target = 15'h0444;
      cycle();
      br_req = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      n_tests++;
      if (s_mem_req !== 1'b0 || s_pc_load !== 1'b1 || s_pc_target !== RV || s_ir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_drain: req=%b load=%b target=%h valid=%b, required 0/1/%h/0", s_mem_req, s_pc_load, s_pc_target, s_ir_valid, RV);
      end
      mem_wait = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (s_ir_valid === 1'b1) break;
         if (s_mem_ack === 1'b1 && s_mem_addr !== RV) early = 1;
      end
      n_tests++;
      if (s_ir_valid !== 1'b1 || s_ir !== mword(RV) || early) begin
         n_fail++;
         $display("FAIL rst_refetch: valid=%b ir=%h bad_addr=%0d, required 1/%h/0", s_ir_valid, s_ir, early, mword(RV));
      end
   endtask

   task automatic test_random();
      int d0;
      do_reset();
      rand_wait = 1;
      d0 = n_deliv;
      for (int i = 0; i < 3000; i++) begin
         if (br_req && ($urandom % 2 == 0)) br_req = 1'b1;
         else br_req = ($urandom % 12 == 0);
         if (br_req && ($urandom % 3 != 0)) br_target = 15'($urandom);
         ir_ready = ($urandom % 4 != 0);
         rst = ($urandom % 500 == 0);
         cycle();
      end
      rst = 1'b0; br_req = 1'b0;
      n_tests++;
      if (n_deliv - d0 < 100) begin
         n_fail++;
         $display("FAIL random_progress: delivered=%0d, required at least 100", n_deliv - d0);
      end
   endtask

   initial begin
      test_reset();
      test_mem_wait();
      test_hold_stall();
      test_branch_drain();
      test_br_hold();
      test_rst_drain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
